// File: rtl/sprite_line_renderer.sv
// Sprite line rasteriser: walks the snapshotted sprite buffer from slot MAX_OBJ-1 down to 0 and writes opaque pixels.
// Optional feature macro SPRITE_FLIP_EN builds the x/y flip muxes; undefined ignores the flip bits.
module sprite_line_renderer #(
    parameter int MAX_OBJ       = 32,
    parameter int OAM_ADDR_SIZE = 6,
    parameter int LINE_WIDTH    = 640
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   line_ready,
    input  logic [MAX_OBJ*(OAM_ADDR_SIZE+1)-1:0]   buffer_array,
    input  logic [9:0]                             sy,
    output logic                                   oam_req,
    output logic [OAM_ADDR_SIZE-1:0]               oam_addr,
    input  logic [31:0]                            oam_data,
    output logic [11:0]                            spr_addr,
    input  logic [63:0]                            spr_data,
    output logic                                   lb_we,
    output logic [9:0]                             lb_addr,
    output logic [4:0]                             lb_data,
    output logic                                   line_done
);

    localparam int SW = OAM_ADDR_SIZE + 1;
    localparam int IW = $clog2(MAX_OBJ);
    localparam logic [IW-1:0] IDX_TOP = IW'(MAX_OBJ - 1);

    typedef enum logic [2:0] {IDLE, SCAN, OAM_LAT, PAT_LAT, DRAW, DONE} state_t;

    state_t                       state;
    logic [IW-1:0]                idx;
    logic [MAX_OBJ*SW-1:0]        buf_snap;
    logic [9:0]                   sy_snap;
    logic                         lr_q;
    logic [9:0]                   x_q;
    logic                         prio_q;
    logic [63:0]                  pat;
    logic [3:0]                   p;

    logic                         rise;
    logic [SW-1:0]                slot;
    logic [9:0]                   row;
    logic                         eligible;
    logic [3:0]                   row_sel;
    logic [63:0]                  nx_pat;
    logic [3:0]                   nx_p;
    logic [3:0]                   nx_s;
    logic [3:0]                   nx_col;
    logic [10:0]                  nx_x;
    logic                         nx_we;

`ifdef SPRITE_FLIP_EN
    logic                         xflip_q;
`else
    logic                         unused_flip_bits;
    assign unused_flip_bits = ^oam_data[30:29];
`endif

    assign rise     = line_ready & ~lr_q;
    assign slot     = buf_snap[int'(idx)*SW +: SW];
    assign row      = sy_snap - oam_data[27:18];
    assign eligible = oam_data[31] && (row[9:4] == 6'd0);

`ifdef SPRITE_FLIP_EN
    assign row_sel  = oam_data[30] ? (4'd15 - row[3:0]) : row[3:0];
`else
    assign row_sel  = row[3:0];
`endif

    // OAM and pattern memories read synchronously, so their addresses leave combinationally.
    always_comb begin
        oam_req  = 1'b0;
        oam_addr = '0;
        spr_addr = '0;
        if (state == SCAN && slot[0]) begin
            oam_req  = 1'b1;
            oam_addr = slot[SW-1:1];
        end
        if (state == OAM_LAT && eligible)
            spr_addr = {oam_data[7:0], row_sel};
    end

    // Next pixel is prepared one cycle ahead so lb_* can be registered yet line up with DRAW cycles.
    always_comb begin
        nx_pat = (state == PAT_LAT) ? spr_data : pat;
        nx_p   = (state == PAT_LAT) ? 4'd0 : p + 4'd1;
        nx_s   = nx_p;
`ifdef SPRITE_FLIP_EN
        if (xflip_q)
            nx_s = 4'd15 - nx_p;
`endif
        nx_col = nx_pat[{nx_s, 2'b00} +: 4];
        nx_x   = {1'b0, x_q} + {7'b0, nx_p};
        nx_we  = (nx_col != 4'd0) && (nx_x < 11'(LINE_WIDTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            buf_snap  <= '0;
            sy_snap   <= '0;
            lr_q      <= 1'b0;
            x_q       <= '0;
            prio_q    <= 1'b0;
            pat       <= '0;
            p         <= '0;
            lb_we     <= 1'b0;
            lb_addr   <= '0;
            lb_data   <= '0;
            line_done <= 1'b0;
`ifdef SPRITE_FLIP_EN
            xflip_q   <= 1'b0;
`endif
        end else begin
            lr_q  <= line_ready;
            lb_we <= 1'b0;
            if (state != IDLE && sy != sy_snap) begin
                state     <= IDLE;
                line_done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (rise) begin
                            buf_snap  <= buffer_array;
                            sy_snap   <= sy;
                            idx       <= IDX_TOP;
                            line_done <= 1'b0;
                            state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (slot[0]) begin
                            state <= OAM_LAT;
                        end else if (idx == '0) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                    OAM_LAT: begin
                        x_q    <= oam_data[17:8];
                        prio_q <= oam_data[28];
`ifdef SPRITE_FLIP_EN
                        xflip_q <= oam_data[29];
`endif
                        if (eligible) begin
                            state <= PAT_LAT;
                        end else if (idx == '0) begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SCAN;
                        end
                    end
                    PAT_LAT: begin
                        pat     <= spr_data;
                        p       <= 4'd0;
                        lb_we   <= nx_we;
                        lb_addr <= nx_x[9:0];
                        lb_data <= {prio_q, nx_col};
                        state   <= DRAW;
                    end
                    DRAW: begin
                        if (p == 4'd15) begin
                            if (idx == '0) begin
                                state     <= DONE;
                                line_done <= 1'b1;
                            end else begin
                                idx   <= idx - 1'b1;
                                state <= SCAN;
                            end
                        end else begin
                            p       <= p + 4'd1;
                            lb_we   <= nx_we;
                            lb_addr <= nx_x[9:0];
                            lb_data <= {prio_q, nx_col};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Scoreboard bench for sprite_line_renderer: a reference walk of the sprite buffer queues expected pattern fetches and writes.
module tb_sprite_line_renderer;

    localparam int MAX_OBJ = 32;
    localparam int SW      = 7;

`ifdef SPRITE_FLIP_EN
    localparam logic [4:0]  XF_X100 = 5'd15;
    localparam logic [4:0]  XF_X114 = 5'd1;
    localparam logic [4:0]  XF_X115 = 5'd0;
    localparam logic [11:0] YF_SPR  = 12'h12A;
`else
    localparam logic [4:0]  XF_X100 = 5'd0;
    localparam logic [4:0]  XF_X114 = 5'd14;
    localparam logic [4:0]  XF_X115 = 5'd15;
    localparam logic [11:0] YF_SPR  = 12'h125;
`endif

    logic                   clk;
    logic                   reset;
    logic                   line_ready;
    logic [MAX_OBJ*SW-1:0]  buffer_array;
    logic [9:0]             sy;
    logic                   oam_req;
    logic [5:0]             oam_addr;
    logic [31:0]            oam_data;
    logic [11:0]            spr_addr;
    logic [63:0]            spr_data;
    logic                   lb_we;
    logic [9:0]             lb_addr;
    logic [4:0]             lb_data;
    logic                   line_done;

    sprite_line_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .line_ready   (line_ready),
        .buffer_array (buffer_array),
        .sy           (sy),
        .oam_req      (oam_req),
        .oam_addr     (oam_addr),
        .oam_data     (oam_data),
        .spr_addr     (spr_addr),
        .spr_data     (spr_data),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_data      (lb_data),
        .line_done    (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] oam_mem [64];
    logic [63:0] pat_mem [256];

    always @(posedge clk) begin
        oam_data <= oam_mem[oam_addr];
        spr_data <= pat_mem[spr_addr[11:4]];
    end

    int          total = 0;
    int          bad   = 0;
    int          wr_count;
    int          low_cnt;
    logic [4:0]  shadow [1024];
    logic [11:0] last_spr;
    logic [14:0] exp_wr [$];
    logic [11:0] exp_spr [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (lb_we) begin
                if (exp_wr.size() == 0)
                    chk("lb_extra", 32'({1'b1, lb_addr, lb_data}), 32'd0);
                else
                    chk("lb_wr", 32'({lb_addr, lb_data}), 32'(exp_wr.pop_front()));
                shadow[lb_addr] = lb_data;
                wr_count++;
                if (lb_addr < 10'd6)
                    low_cnt++;
            end
            if (spr_addr != 12'd0) begin
                if (exp_spr.size() == 0)
                    chk("spr_extra", 32'({1'b1, spr_addr}), 32'd0);
                else
                    chk("spr_addr", 32'(spr_addr), 32'(exp_spr.pop_front()));
                last_spr = spr_addr;
            end
        end
    end

    function automatic logic [31:0] mk_oam(input logic [7:0] rf, input logic [9:0] x, input logic [9:0] y,
                                           input logic pr, input logic xf, input logic yf, input logic en);
        return {en, yf, xf, pr, y, x, rf};
    endfunction

    task automatic clear_tb();
        exp_wr.delete();
        exp_spr.delete();
        wr_count = 0;
        low_cnt  = 0;
        last_spr = 12'd0;
        for (int i = 0; i < 1024; i++) shadow[i] = 5'd0;
    endtask

    // Reference walk: slot 31 down to 0, queues fetches/writes and returns cycles from first SCAN to DONE.
    task automatic build_expect(output int n);
        logic [6:0]  slot;
        logic [31:0] o;
        logic [9:0]  row;
        logic [3:0]  r;
        logic [3:0]  s;
        logic [3:0]  col;
        logic [10:0] xx;
        logic [63:0] pt;
        n = 0;
        for (int i = MAX_OBJ - 1; i >= 0; i--) begin
            slot = buffer_array[i*SW +: SW];
            if (!slot[0]) begin
                n += 1;
                continue;
            end
            o   = oam_mem[slot[6:1]];
            row = sy - o[27:18];
            if (!o[31] || row >= 10'd16) begin
                n += 2;
                continue;
            end
            n += 19;
            r = row[3:0];
`ifdef SPRITE_FLIP_EN
            if (o[30]) r = 4'd15 - row[3:0];
`endif
            exp_spr.push_back({o[7:0], r});
            pt = pat_mem[o[7:0]];
            for (int q = 0; q < 16; q++) begin
                s = 4'(q);
`ifdef SPRITE_FLIP_EN
                if (o[29]) s = 4'(15 - q);
`endif
                col = pt[s*4 +: 4];
                xx  = {1'b0, o[17:8]} + 11'(q);
                if (col != 4'd0 && xx < 11'd640)
                    exp_wr.push_back({xx[9:0], o[28], col});
            end
        end
    endtask

    task automatic run_line(input string tag, input logic [9:0] new_sy);
        int n;
        int c;
        clear_tb();
        line_ready = 1'b0;
        sy = new_sy;
        build_expect(n);
        repeat (3) @(posedge clk);
        #1 line_ready = 1'b1;
        c = 0;
        do begin
            @(posedge clk);
            #1 c++;
        end while (!line_done && c < 2000);
        chk({tag, "_lat"}, 32'(c), 32'(n + 1));
        repeat (2) @(negedge clk);
        chk({tag, "_left"}, 32'(exp_wr.size() + exp_spr.size()), 32'd0);
    endtask

    logic [9:0] rsy;
    logic [5:0] ri;

    initial begin
        reset = 1'b1;
        line_ready = 1'b0;
        sy = 10'd0;
        buffer_array = '0;
        for (int i = 0; i < 64; i++) oam_mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) pat_mem[i] = {$urandom, $urandom};
        clear_tb();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lb",  32'({lb_we, lb_addr, lb_data}), 32'd0);
        chk("rst_ctl", 32'({line_done, oam_req, oam_addr, spr_addr}), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        buffer_array[0 +: SW] = {6'd5, 1'b1};
        oam_mem[5] = mk_oam(8'h12, 10'd100, 10'd40, 1'b0, 1'b0, 1'b0, 1'b1);
        pat_mem[8'h12] = 64'hFEDCBA9876543210;
        run_line("single", 10'd45);
        chk("single_spr",  32'(last_spr), 32'h125);
        chk("single_nwr",  32'(wr_count), 32'd15);
        chk("single_x100", 32'(shadow[100]), 32'd0);
        chk("single_x115", 32'(shadow[115]), 32'd15);

        oam_mem[5] = mk_oam(8'h12, 10'd100, 10'd40, 1'b0, 1'b1, 1'b0, 1'b1);
        run_line("xflip", 10'd45);
        chk("xflip_x100", 32'(shadow[100]), 32'(XF_X100));
        chk("xflip_x114", 32'(shadow[114]), 32'(XF_X114));
        chk("xflip_x115", 32'(shadow[115]), 32'(XF_X115));

        oam_mem[5] = mk_oam(8'h12, 10'd100, 10'd40, 1'b0, 1'b0, 1'b1, 1'b1);
        run_line("yflip", 10'd45);
        chk("yflip_spr", 32'(last_spr), 32'(YF_SPR));

        buffer_array = '0;
        buffer_array[0 +: SW]  = {6'd1, 1'b1};
        buffer_array[SW +: SW] = {6'd2, 1'b1};
        oam_mem[1] = mk_oam(8'h31, 10'd200, 10'd40, 1'b0, 1'b0, 1'b0, 1'b1);
        oam_mem[2] = mk_oam(8'h32, 10'd200, 10'd40, 1'b0, 1'b0, 1'b0, 1'b1);
        pat_mem[8'h31] = 64'h3333333333333333;
        pat_mem[8'h32] = 64'h7777777777777777;
        run_line("ovl", 10'd50);
        chk("ovl_x200", 32'(shadow[200]), 32'd3);
        chk("ovl_x215", 32'(shadow[215]), 32'd3);
        chk("ovl_nwr",  32'(wr_count), 32'd32);

        buffer_array = '0;
        buffer_array[3*SW +: SW] = {6'd9, 1'b1};
        oam_mem[9] = mk_oam(8'h40, 10'd630, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1);
        pat_mem[8'h40] = 64'h1111111111111111;
        run_line("edge", 10'd52);
        chk("edge_low",  32'(low_cnt), 32'd0);
        chk("edge_x639", 32'(shadow[639]), 32'd1);
        chk("edge_nwr",  32'(wr_count), 32'd10);

        buffer_array = '0;
        buffer_array[10*SW +: SW] = {6'd10, 1'b1};
        buffer_array[11*SW +: SW] = {6'd11, 1'b1};
        buffer_array[12*SW +: SW] = {6'd12, 1'b1};
        buffer_array[13*SW +: SW] = {6'd13, 1'b1};
        oam_mem[10] = mk_oam(8'h50, 10'd20, 10'd60, 1'b1, 1'b0, 1'b0, 1'b1);
        oam_mem[11] = mk_oam(8'h51, 10'd40, 10'd59, 1'b0, 1'b0, 1'b0, 1'b1);
        oam_mem[12] = mk_oam(8'h52, 10'd60, 10'd70, 1'b0, 1'b0, 1'b0, 1'b0);
        oam_mem[13] = mk_oam(8'h53, 10'd80, 10'd76, 1'b0, 1'b0, 1'b0, 1'b1);
        pat_mem[8'h50] = 64'hF0F0F0F0F0F0F0F0;
        run_line("misc", 10'd75);
        chk("misc_pri", 32'(shadow[21]), 32'h1F);

        buffer_array = '0;
        run_line("empty", 10'd80);
        chk("empty_nwr", 32'(wr_count), 32'd0);

        for (int t = 0; t < 4; t++) begin
            buffer_array = '0;
            rsy = 10'($urandom_range(20, 470));
            for (int s = 0; s < MAX_OBJ; s++) begin
                if ($urandom_range(0, 2) == 0) begin
                    ri = 6'($urandom_range(0, 63));
                    buffer_array[s*SW +: SW] = {ri, 1'b1};
                end
            end
            for (int k = 0; k < 64; k++)
                oam_mem[k] = mk_oam(8'($urandom_range(1, 255)), 10'($urandom_range(0, 639)),
                                    rsy - 10'($urandom_range(0, 20)), 1'($urandom), 1'($urandom),
                                    1'($urandom), ($urandom_range(0, 5) != 0));
            run_line("rand", rsy);
        end

        clear_tb();
        line_ready = 1'b0;
        sy = 10'd100;
        buffer_array = '0;
        buffer_array[31*SW +: SW] = {6'd7, 1'b1};
        oam_mem[7] = mk_oam(8'h20, 10'd10, 10'd100, 1'b0, 1'b0, 1'b0, 1'b1);
        pat_mem[8'h20] = 64'h1111111111111111;
        exp_spr.push_back(12'h200);
        for (int q = 0; q < 5; q++) exp_wr.push_back({10'(10 + q), 5'h01});
        repeat (3) @(posedge clk);
        #1 line_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 sy = 10'd101;
        @(posedge clk);
        #1;
        chk("abort_we",   32'(lb_we), 32'd0);
        chk("abort_done", 32'(line_done), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_nwr",  32'(wr_count), 32'd5);
        chk("abort_left", 32'(exp_wr.size() + exp_spr.size()), 32'd0);
        chk("abort_idle", 32'({line_done, oam_req}), 32'd0);

        clear_tb();
        line_ready = 1'b0;
        sy = 10'd100;
        exp_spr.push_back(12'h200);
        exp_wr.push_back({10'd10, 5'h01});
        repeat (3) @(posedge clk);
        #1 line_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_lb",  32'({lb_we, lb_addr, lb_data}), 32'd0);
        chk("rstmid_ctl", 32'({line_done, oam_req, oam_addr, spr_addr}), 32'd0);
        line_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("rstmid_nwr",  32'(wr_count), 32'd1);
        chk("rstmid_left", 32'(exp_wr.size() + exp_spr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Sprite rasteriser stage directly downstream of the per-line sprite evaluator. On each "line prepared" pulse it walks the 32-entry sprite buffer and re-reads each listed OAM entry. It fetches the matching 16-pixel pattern row from sprite memory and writes opaque pixels into the scanline buffer for the next displayed line. Entries are drawn from buffer slot 31 down to 0, so lower-numbered slots overwrite higher ones and win overlaps.

## Interface
- MAX_OBJ, 32, sprite buffer entries.
- OAM_ADDR_SIZE, 6, OAM index width.
- LINE_WIDTH, 640, visible pixels per line; writes at x ≥ LINE_WIDTH are dropped.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- line_ready  in  1  level from evaluator; rising edge starts a render.
- buffer_array  in  MAX_OBJ×(OAM_ADDR_SIZE+1)  slot bit0 = valid, bits [6:1] = OAM index.
- sy  in  10  current evaluation line.
- oam_req  out  1  high while this block owns the OAM read port.
- oam_addr  out  OAM_ADDR_SIZE  OAM read address; synchronous read, data valid the next cycle.
- oam_data  in  32  [7:0] spriteref, [17:8] x, [27:18] y, [28] priority, [29] xflip, [30] yflip, [31] enable.
- spr_addr  out  12  {spriteref, row[3:0]}; synchronous read, data valid the next cycle.
- spr_data  in  64  16 pixels × 4-bit colour; pixel i = bits [4i+3:4i], i=0 leftmost.
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  10  pixel x.
- lb_data  out  5  {priority, colour[3:0]}.
- line_done  out  1  high from end of render until next start or sy change.

## Operation
- The line-buffer owner clears the buffer; this block writes opaque pixels only.
- The block snapshots buffer_array and sy at start. Later changes to buffer_array are ignored.
- States are IDLE, SCAN, OAM_LAT, PAT_LAT, DRAW, DONE.
- IDLE: on a line_ready rising edge, set idx=MAX_OBJ-1, line_done=0, go to SCAN.
- SCAN: examine snapshot slot idx.
  - Valid: oam_req=1, oam_addr=slot index (combinational), go to OAM_LAT.
  - Invalid, idx>0: idx-1, stay in SCAN.
  - Invalid, idx=0: go to DONE.
- OAM_LAT: latch oam_data fields and compute row = sy_snap − y, 10-bit.
  - If enable=0 or row ≥ 16 unsigned: skip to the next slot (same idx rule as SCAN).
  - Otherwise drive spr_addr={spriteref, r}, where r = row[3:0], or 15−row[3:0] when yflip. Go to PAT_LAT.
- PAT_LAT: latch spr_data, set pixel counter p=0, go to DRAW.
- DRAW: 16 cycles, p = 0..15.
  - Pixel select is s = xflip ? 15−p : p.
  - Write when colour(s) ≠ 0 and x+p < LINE_WIDTH: lb_we=1, lb_addr=x+p, lb_data={priority, colour(s)}.
  - x+p is computed in 11 bits, so there is no wrap to low x.
  - After p=15: next slot, or DONE if idx=0.
- DONE: line_done=1, hold. A new line_ready rising edge restarts the render.
- sy ≠ sy_snap in any non-IDLE state aborts: go to IDLE next cycle, lb_we=0, line_done=0.
- A line_ready rising edge while busy is ignored unless sy also changed.

## Timing
- Reset values are all zero: oam_req, oam_addr, spr_addr, lb_we, lb_addr, lb_data, line_done. State is IDLE.
- Reset mid-render returns to IDLE immediately with no further writes.
- Start latency: line_ready edge sampled at cycle 0, SCAN in cycle 1.
- Invalid slot: 1 cycle. Valid sprite but off-line or disabled: 2 cycles. Drawn sprite: 19 cycles (SCAN, OAM_LAT, PAT_LAT, 16×DRAW).
- First lb_we of a drawn sprite falls 3 cycles after its SCAN cycle.
- Worst case (32 drawn sprites): 608 cycles from first SCAN to DONE.
- lb_* outputs are registered, with one write per cycle maximum.
- line_done asserts the cycle after the final slot's last state.

## Configuration
- SPRITE_FLIP_EN defined: xflip and yflip are honoured as described.
- SPRITE_FLIP_EN undefined: both bits are ignored (r=row[3:0], s=p) and the flip muxes are not built.

## Test plan
- Single sprite, slot 0 = {idx 5, valid}, OAM[5]: ref=0x12, x=100, y=40, enable=1; sy=45; spr_data pixel i colour = i → spr_addr=0x125, 15 writes at x=101..115 with colour 1..15 (pixel 0 skipped), line_done after 19+ cycles.
- Same sprite with xflip=1 → x=100 gets colour 15, x=114 gets colour 1, x=115 is not written. With yflip=1 → spr_addr=0x12A. Under undefined SPRITE_FLIP_EN → identical to the unflipped case.
- Overlap: slot 0 = sprite A colour 3, slot 1 = sprite B colour 7, both at x=200 → B's writes precede A's, so A's colour 3 is the last value written at x=200..215.
- Right edge: x=630 → writes only at x=630..639, never at x=0..5.
- Empty buffer (all invalid) → no lb_we, line_done exactly 32 cycles after the first SCAN.
- Abort: change sy during the 5th DRAW cycle → lb_we low from the next cycle, state IDLE, line_done=0. Assert reset mid-DRAW → all outputs 0 asynchronously.
